// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the bit-serial pattern detector controller.
package seq_detect_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_PAT_W  = 4;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Lengths beyond the history depth behave as a full-depth compare.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
        return (len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Valid/ready word ingress for seq_detect_ctrl.
interface seq_detect_ctrl_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/seq_bit_matcher.sv
// Continuous-bitstream pattern matcher with history and fill tracking.
// SEQ_DETECT_CTRL_OVERLAP_EN keeps history and fill after a match (overlapping detections).
module seq_bit_matcher
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stream_bit,
    input  logic             bit_vld,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_nxt;
    logic [LEN_W-1:0] len_c;

    always_comb begin
        len_c    = LEN_W'(clamp_len(32'(len), PAT_W));
        hist_nxt = {hist[PAT_W-2:0], stream_bit};
        fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        mask     = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_c));
        end
        match = bit_vld && (len_c != '0) && (fill_nxt >= len_c) &&
                ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_vld) begin
            hist <= hist_nxt;
`ifdef SEQ_DETECT_CTRL_OVERLAP_EN
            fill <= fill_nxt;
`else
            // Restarting the fill forces the next match onto fresh bits.
            fill <= match ? '0 : fill_nxt;
`endif
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Streaming controller: serialises words MSB-first into seq_bit_matcher, counts hits, raises sticky irq.
// Optional SEQ_DETECT_CTRL_OVERLAP_EN selects overlapping detections inside the matcher.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAT_W  = DEF_PAT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned LEN_W  = $clog2(PAT_W) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_ctrl_if.slave   s,
    input  logic               cfg_en,
    input  logic               cfg_clear,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    output logic               det_pulse,
    output logic [CNT_W-1:0]   det_count,
    output logic               irq,
    output logic               busy
);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shifter;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_bit;
    logic              ready;
    logic              accept;
    logic              shift_en;
    logic              match;
    logic [CNT_W-1:0]  cnt_inc;

    assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
    assign cnt_inc  = (det_count == '1) ? det_count : det_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it reads low for the whole reset window.
    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        shift_en = 1'b0;
        case (state)
            IDLE:  ready = cfg_en && rst_n;
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                ready    = cfg_en && last_bit && rst_n;
            end
            default: ;
        endcase
        accept    = s.s_valid && ready;
        s.s_ready = ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            shifter <= s.s_data;
            bit_idx <= '0;
        end else if (shift_en) begin
            shifter <= {shifter[DATA_W-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
        end
    end

    seq_bit_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk        (clk),
        .rst_n      (rst_n),
        .stream_bit (shifter[DATA_W-1]),
        .bit_vld    (shift_en),
        .clear      (cfg_clear),
        .pattern    (cfg_pattern),
        .len        (cfg_len),
        .match      (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_pulse <= 1'b0;
            det_count <= '0;
            irq       <= 1'b0;
        end else begin
            det_pulse <= match && !cfg_clear;
            if (cfg_clear) begin
                det_count <= '0;
                irq       <= 1'b0;
            end else if (match) begin
                det_count <= cnt_inc;
                if ((cfg_thresh != '0) && (cnt_inc >= cfg_thresh)) irq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: vector table, directed corner cases, randomized run vs reference model.
module tb_seq_detect_ctrl;

    localparam int DW   = 8;
    localparam int PW   = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;
`ifdef SEQ_DETECT_CTRL_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic          cfg_clear;
    logic [PW-1:0] cfg_pattern;
    logic [2:0]    cfg_len;
    logic [CW-1:0] cfg_thresh;
    logic          det_pulse;
    logic [CW-1:0] det_count;
    logic          irq;
    logic          busy;

    seq_detect_ctrl_if #(.DATA_W(DW)) bus ();

    seq_detect_ctrl #(
        .DATA_W (DW),
        .PAT_W  (PW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (bus),
        .cfg_en      (cfg_en),
        .cfg_clear   (cfg_clear),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .det_pulse   (det_pulse),
        .det_count   (det_count),
        .irq         (irq),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    // Reference model: bits remaining in the current word plus the recent bitstream.
    int            rem;
    logic [DW-1:0] cur;
    bit            hq[$];
    int            avail;
    int            cnt_m;
    bit            irq_m;
    bit            pulse_m;
    bit            acc_m;

    typedef struct {
        logic [PW-1:0] pat;
        logic [2:0]    len;
        logic [DW-1:0] word;
        int            exp_non;
        int            exp_ov;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return (rst_n === 1'b1) && (cfg_en === 1'b1) && (rem <= 1);
    endfunction

    task automatic model_reset();
        rem = 0; hq.delete(); avail = 0; cnt_m = 0; irq_m = 0; pulse_m = 0; acc_m = 0;
    endtask

    task automatic model_edge();
        int L;
        bit m;
        bit b;
        acc_m   = bus.s_valid && exp_ready();
        pulse_m = 0;
        L = (int'(cfg_len) > PW) ? PW : int'(cfg_len);
        if (rem > 0) begin
            b = cur[rem-1];
            rem--;
            hq.push_back(b);
            if (hq.size() > PW) void'(hq.pop_front());
            avail++;
            m = (L > 0) && (avail >= L);
            for (int j = 0; j < L; j++)
                if (m && (hq[hq.size()-1-j] != cfg_pattern[j])) m = 0;
            if (m) begin
                pulse_m = 1;
                if (cnt_m < CMAX) cnt_m++;
                if ((cfg_thresh != 0) && (cnt_m >= int'(cfg_thresh))) irq_m = 1;
                if (!OV) avail = 0;
            end
        end
        if (cfg_clear) begin
            hq.delete(); avail = 0; cnt_m = 0; irq_m = 0; pulse_m = 0;
        end
        if (acc_m) begin
            cur = bus.s_data;
            rem = DW;
        end
    endtask

    task automatic tick();
        #1;
        check("s_ready", int'(bus.s_ready), int'(exp_ready()));
        @(posedge clk);
        if (rst_n !== 1'b1) model_reset();
        else model_edge();
        #1;
        check("busy", int'(busy), int'(rem > 0));
        check("det_pulse", int'(det_pulse), int'(pulse_m));
        check("det_count", int'(det_count), cnt_m);
        check("irq", int'(irq), int'(irq_m));
        if (det_pulse) pulse_cnt++;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit got;
        got = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            got = acc_m;
        end
        bus.s_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && rem != 0; i++) tick();
        if (rem != 0) check("idle_timeout", rem, 0);
    endtask

    task automatic do_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        int accepts;
        int drops;
        int words;

        vecs[0] = '{4'b1011, 3'd4, 8'hB6, 1, 2};
        vecs[1] = '{4'b0000, 3'd2, 8'h00, 4, 7};
        vecs[2] = '{4'b1111, 3'd0, 8'hFF, 0, 0};
        vecs[3] = '{4'b1111, 3'd7, 8'hFF, 2, 5};
        vecs[4] = '{4'b0001, 3'd1, 8'hA5, 4, 4};
        vecs[5] = '{4'b0110, 3'd4, 8'h66, 2, 2};
        vecs[6] = '{4'b0101, 3'd3, 8'hAA, 2, 3};

        rst_n = 1'b0; cfg_en = 1'b0; cfg_clear = 1'b0;
        cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_thresh = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_s_ready", int'(bus.s_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_det_pulse", int'(det_pulse), 0);
        check("reset_det_count", int'(det_count), 0);
        check("reset_irq", int'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_en = 1'b1;
        tick();

        // Detection latency for 1011 in 0xB6.
        pulse_cnt = 0;
        send_word(8'hB6);
        tick(); tick(); tick();
        check("t1_early_pulses", pulse_cnt, 0);
        tick();
        check("t1_pulse_latency", int'(det_pulse), 1);
        wait_idle(); tick(); tick();
        check("t1_count", int'(det_count), OV ? 2 : 1);

        foreach (vecs[k]) begin
            wait_idle();
            cfg_pattern = vecs[k].pat;
            cfg_len     = vecs[k].len;
            do_clear();
            pulse_cnt = 0;
            send_word(vecs[k].word);
            wait_idle(); tick(); tick();
            check("vec_pulses", pulse_cnt, OV ? vecs[k].exp_ov : vecs[k].exp_non);
            check("vec_count", int'(det_count), OV ? vecs[k].exp_ov : vecs[k].exp_non);
        end

        // Back-to-back words with s_valid held high.
        wait_idle();
        send_word(8'h3C);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        rdy_cnt = 0; accepts = 0; drops = 0;
        for (int i = 0; i < 23; i++) begin
            #1;
            if (bus.s_ready) rdy_cnt++;
            tick();
            if (acc_m) accepts++;
            if (!busy) drops++;
            if (accepts == 2) bus.s_valid = 1'b0;
        end
        bus.s_valid = 1'b0;
        check("b2b_ready_count", rdy_cnt, 2);
        check("b2b_accepts", accepts, 2);
        check("b2b_busy_drops", drops, 0);
        tick();
        check("b2b_idle_after_24", int'(busy), 0);

        // Threshold interrupt.
        cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_thresh = 8'd3;
        do_clear();
        pulse_cnt = 0;
        words = 0;
        while (pulse_cnt < 3 && words < 6) begin
            check("irq_before_thresh", int'(irq), 0);
            send_word(8'hB6);
            wait_idle(); tick();
            words++;
        end
        check("irq_set", int'(irq), 1);
        send_word(8'h00);
        wait_idle(); tick();
        check("irq_sticky", int'(irq), 1);
        do_clear();
        check("irq_cleared", int'(irq), 0);
        check("count_cleared", int'(det_count), 0);

        // Counter saturation: every bit matches.
        cfg_pattern = 4'b0001; cfg_len = 3'd1; cfg_thresh = '0;
        do_clear();
        for (int w = 0; w < 40; w++) send_word(8'hFF);
        wait_idle(); tick();
        check("count_saturated", int'(det_count), CMAX);
        check("irq_thresh_zero", int'(irq), 0);

        // Clear coinciding with a match.
        do_clear();
        send_word(8'hFF);
        tick(); tick();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clear_wins_pulse", int'(det_pulse), 0);
        check("clear_wins_count", int'(det_count), 0);
        tick();
        check("after_clear_pulse", int'(det_pulse), 1);
        check("after_clear_count", int'(det_count), 1);
        wait_idle();

        // Async reset mid-word.
        cfg_pattern = 4'b1011; cfg_len = 3'd4;
        send_word(8'hB6);
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("arst_s_ready", int'(bus.s_ready), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_det_pulse", int'(det_pulse), 0);
        check("arst_det_count", int'(det_count), 0);
        check("arst_irq", int'(irq), 0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        send_word(8'h0F);
        check("arst_new_word_busy", int'(busy), 1);
        wait_idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (rem == 0 && ($urandom % 8) == 0) begin
                cfg_pattern = PW'($urandom);
                cfg_len     = 3'($urandom % 6);
                cfg_thresh  = CW'($urandom % 12);
            end
            cfg_en      = ($urandom % 8) != 0;
            cfg_clear   = ($urandom % 40) == 0;
            bus.s_valid = $urandom % 2;
            bus.s_data  = DW'($urandom);
            tick();
        end
        cfg_clear = 1'b0;
        bus.s_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
